episode_controller: RTL and testbench

Top-level sequencer for Dyna-Q training. It runs episodes, steps the environment, and issues one real Q-table update per step followed by PLAN_STEPS model-based planning updates. After each step it tests two end conditions: the goal reward (reward is all-ones) and the step limit (step_count == MAX_STEPS). It counts episodes up to MAX_EPISODES and sits between the environment/action-select unit and the shared Q-update datapath.

---
 rtl/episode_controller.sv | 134 +++++++++++++
 tb/tb_episode_controller.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/episode_controller.sv
// Dyna-Q episode sequencer: per real step, one real Q-update then PLAN_STEPS planning updates,
// followed by goal / step-limit checks and episode counting.
module episode_controller #(
    parameter int unsigned REWARD_LENGTH  = 10,
    parameter int unsigned STEP_LENGTH    = 5,
    parameter int unsigned MAX_STEPS      = 25,
    parameter int unsigned PLAN_LENGTH    = 4,
    parameter int unsigned PLAN_STEPS     = 5,
    parameter int unsigned EPISODE_LENGTH = 8,
    parameter int unsigned MAX_EPISODES   = 200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      env_done,
    input  logic [REWARD_LENGTH-1:0]  reward,
    input  logic                      qupd_done,
    output logic                      act_req,
    output logic                      qupd_req,
    output logic                      qupd_plan,
    output logic                      env_reset,
    output logic                      episode_end,
    output logic                      end_cause,
    output logic [STEP_LENGTH-1:0]    step_count,
    output logic [EPISODE_LENGTH-1:0] episode_count,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        StIdle, StEpStart, StAct, StUpdate, StPlan, StCheck, StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [STEP_LENGTH-1:0]    step_q, step_d;
    logic [PLAN_LENGTH-1:0]    plan_q, plan_d;
    logic [EPISODE_LENGTH-1:0] ep_q, ep_d;
    logic [REWARD_LENGTH-1:0]  reward_q, reward_d;

    logic                      goal, limit, ep_end;
    logic [EPISODE_LENGTH-1:0] ep_inc;

    assign goal   = &reward_q;
    assign limit  = (step_q == STEP_LENGTH'(MAX_STEPS));
    assign ep_end = (state_q == StCheck) && (goal || limit);
    assign ep_inc = ep_q + EPISODE_LENGTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            plan_q   <= '0;
            ep_q     <= '0;
            reward_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            plan_q   <= plan_d;
            ep_q     <= ep_d;
            reward_q <= reward_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        plan_d   = plan_q;
        ep_d     = ep_q;
        reward_d = reward_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ep_d    = '0;
                    state_d = StEpStart;
                end
            end
            StEpStart: begin
                step_d  = '0;
                state_d = StAct;
            end
            StAct: begin
                if (env_done) begin
                    reward_d = reward;
                    state_d  = StUpdate;
                end
            end
            StUpdate: begin
                if (qupd_done) begin
                    step_d  = step_q + STEP_LENGTH'(1);
                    plan_d  = '0;
                    state_d = (PLAN_STEPS > 0) ? StPlan : StCheck;
                end
            end
            StPlan: begin
                if (qupd_done) begin
                    plan_d = plan_q + PLAN_LENGTH'(1);
                    if (plan_q == PLAN_LENGTH'(PLAN_STEPS - 1)) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (goal || limit) begin
                    ep_d    = ep_inc;
                    state_d = (ep_inc == EPISODE_LENGTH'(MAX_EPISODES)) ? StDone : StEpStart;
                end else begin
                    state_d = StAct;
                end
            end
            StDone: begin
                if (start) begin
                    ep_d    = '0;
                    state_d = StEpStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend only on registered state; the CHECK cycle already shows the bumped count.
    always_comb begin
        act_req       = (state_q == StAct);
        qupd_req      = (state_q == StUpdate) || (state_q == StPlan);
        qupd_plan     = (state_q == StPlan);
        env_reset     = (state_q == StEpStart);
        episode_end   = ep_end;
        end_cause     = ep_end && !goal;
        step_count    = step_q;
        episode_count = ep_end ? ep_inc : ep_q;
        busy          = (state_q != StIdle) && (state_q != StDone);
        done          = (state_q == StDone);
    end

endmodule

// File: tb/tb_episode_controller.sv
// Randomized self-checking bench for episode_controller; a second instance (2 episodes,
// no planning) with zero-latency responders covers completion and restart.
module tb_episode_controller;

    localparam int P     = 5;
    localparam int MAXS  = 25;
    localparam int GOAL  = 1023;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, env_done = 1'b0, qupd_done = 1'b0;
    logic [9:0] reward = '0;
    logic       act_req, qupd_req, qupd_plan, env_reset, episode_end, end_cause, busy, done;
    logic [4:0] step_count;
    logic [7:0] episode_count;

    logic       start2 = 1'b0;
    logic       env_done2, qupd_done2;
    logic [9:0] reward2;
    logic       act_req2, qupd_req2, qupd_plan2, env_reset2, episode_end2, end_cause2;
    logic       busy2, done2;
    logic [4:0] step_count2;
    logic [7:0] episode_count2;

    wire [7:0] outs  = {act_req, qupd_req, qupd_plan, env_reset, episode_end, end_cause, busy,
                        done};
    wire [7:0] outs2 = {act_req2, qupd_req2, qupd_plan2, env_reset2, episode_end2, end_cause2,
                        busy2, done2};

    int n_tests = 0;
    int n_fail  = 0;
    int ep_model = 0;

    always #5 clk = ~clk;

    episode_controller dut (
        .clk(clk), .rst(rst), .start(start), .env_done(env_done), .reward(reward),
        .qupd_done(qupd_done), .act_req(act_req), .qupd_req(qupd_req), .qupd_plan(qupd_plan),
        .env_reset(env_reset), .episode_end(episode_end), .end_cause(end_cause),
        .step_count(step_count), .episode_count(episode_count), .busy(busy), .done(done)
    );

    // Zero-latency responders that always deliver the goal reward.
    assign env_done2  = act_req2;
    assign qupd_done2 = qupd_req2;
    assign reward2    = 10'(GOAL);

    episode_controller #(.MAX_EPISODES(2), .PLAN_STEPS(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .env_done(env_done2), .reward(reward2),
        .qupd_done(qupd_done2), .act_req(act_req2), .qupd_req(qupd_req2),
        .qupd_plan(qupd_plan2), .env_reset(env_reset2), .episode_end(episode_end2),
        .end_cause(end_cause2), .step_count(step_count2), .episode_count(episode_count2),
        .busy(busy2), .done(done2)
    );

    // Reference: an episode ends at the first goal reward, or at MAX_STEPS otherwise.
    function automatic void model_episode(input int rews[$], output int end_step,
                                          output int cause);
        end_step = MAXS;
        cause    = 1;
        for (int i = 0; i < MAXS; i++) begin
            if (rews[i] == GOAL) begin
                end_step = i + 1;
                cause    = 0;
                break;
            end
        end
    endfunction

    // Drives one real step plus its planning updates; returns at the CHECK-cycle negedge.
    task automatic run_step(input int rew, input int max_lat, output int n_real,
                            output int n_plan, output int seq_err, output int cyc,
                            output int tmo);
        int lat;
        n_real = 0; n_plan = 0; seq_err = 0; cyc = 0; tmo = 0;
        for (int c = 0; c < 64 && act_req !== 1'b1; c++) @(negedge clk);
        if (act_req !== 1'b1) begin tmo = 1; return; end
        lat = $urandom_range(0, max_lat);
        repeat (lat) begin
            @(negedge clk); cyc++;
            if (act_req !== 1'b1) seq_err++;
        end
        env_done = 1'b1; reward = 10'(rew);
        @(negedge clk); cyc++;
        env_done = 1'b0; reward = 10'($urandom);
        for (int k = 0; k <= P; k++) begin
            for (int c = 0; c < 64 && qupd_req !== 1'b1; c++) begin @(negedge clk); cyc++; end
            if (qupd_req !== 1'b1) begin tmo = 1; return; end
            if (qupd_plan !== (k > 0)) seq_err++;
            if (qupd_plan === 1'b1) n_plan++; else n_real++;
            lat = $urandom_range(0, max_lat);
            repeat (lat) begin
                @(negedge clk); cyc++;
                if (qupd_req !== 1'b1) seq_err++;
            end
            qupd_done = 1'b1;
            @(negedge clk); cyc++;
            qupd_done = 1'b0;
        end
    endtask

    task automatic run_episode(input int rews[$], input int max_lat, output int end_idx,
                               output int cause, output int steps, output int epc,
                               output int n_real, output int n_plan, output int bad);
        int r, p, e, c, t;
        end_idx = 0; cause = -1; steps = -1; epc = -1; n_real = 0; n_plan = 0; bad = 0;
        for (int s = 0; s < MAXS + 3 && end_idx == 0; s++) begin
            run_step((s < rews.size()) ? rews[s] : 0, max_lat, r, p, e, c, t);
            n_real += r; n_plan += p; bad += e + t;
            if (t != 0) break;
            if (qupd_req !== 1'b0 || step_count !== 5'(s + 1)) bad++;
            if (episode_end === 1'b1) begin
                end_idx = s + 1; cause = int'(end_cause);
                steps = int'(step_count); epc = int'(episode_count);
            end
        end
    endtask

    task automatic test_reset();
        int idle_bad = 0;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom); env_done = 1'($urandom); qupd_done = 1'($urandom);
            reward = 10'($urandom);
        end
        @(negedge clk);
        n_tests++;
        if (outs !== 8'h0 || step_count !== 5'd0 || episode_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: outs=%b step=%0d ep=%0d, required all 0", outs,
                     step_count, episode_count);
        end
        n_tests++;
        if (outs2 !== 8'h0 || episode_count2 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state2: outs=%b ep=%0d, required all 0", outs2, episode_count2);
        end
        rst = 1'b0; start = 1'b0;
        repeat (8) begin
            env_done = 1'($urandom); qupd_done = 1'($urandom);
            @(negedge clk);
            if (outs !== 8'h0 || step_count !== 5'd0 || episode_count !== 8'd0) idle_bad++;
        end
        env_done = 1'b0; qupd_done = 1'b0;
        n_tests++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, required 0", idle_bad);
        end
    endtask

    task automatic test_goal_first();
        int r, p, e, c, t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (env_reset !== 1'b1 || busy !== 1'b1 || act_req !== 1'b0) begin
            n_fail++;
            $display("FAIL start_env_reset: env_reset=%b busy=%b act_req=%b, required 1 1 0",
                     env_reset, busy, act_req);
        end
        @(negedge clk);
        n_tests++;
        if (act_req !== 1'b1 || env_reset !== 1'b0 || step_count !== 5'd0) begin
            n_fail++;
            $display("FAIL start_act: act_req=%b env_reset=%b step=%0d, required 1 0 0",
                     act_req, env_reset, step_count);
        end
        run_step(GOAL, 0, r, p, e, c, t);
        ep_model++;
        n_tests++;
        if (t != 0 || e != 0 || r != 1 || p != P) begin
            n_fail++;
            $display("FAIL goal1_updates: real=%0d plan=%0d err=%0d tmo=%0d, required 1 %0d 0 0",
                     r, p, e, t, P);
        end
        n_tests++;
        if (c != P + 2) begin
            n_fail++;
            $display("FAIL goal1_latency: CHECK reached after %0d cycles, required %0d", c, P + 2);
        end
        n_tests++;
        if (episode_end !== 1'b1 || end_cause !== 1'b0 || qupd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL goal1_end: end=%b cause=%b qupd_req=%b, required 1 0 0",
                     episode_end, end_cause, qupd_req);
        end
        n_tests++;
        if (step_count !== 5'd1 || episode_count !== 8'(ep_model)) begin
            n_fail++;
            $display("FAIL goal1_counts: step=%0d ep=%0d, required 1 %0d", step_count,
                     episode_count, ep_model);
        end
        @(negedge clk);
        n_tests++;
        if (env_reset !== 1'b1 || episode_end !== 1'b0 || episode_count !== 8'(ep_model)) begin
            n_fail++;
            $display("FAIL goal1_restart: env_reset=%b end=%b ep=%0d, required 1 0 %0d",
                     env_reset, episode_end, episode_count, ep_model);
        end
    endtask

    // Common body for fixed-reward episodes, checked against the reference model.
    task automatic check_episode(input string name, input int rews[$], input int max_lat,
                                 input int check_totals);
        int end_idx, cause, steps, epc, nr, np, bad, exp_end, exp_cause;
        model_episode(rews, exp_end, exp_cause);
        run_episode(rews, max_lat, end_idx, cause, steps, epc, nr, np, bad);
        ep_model++;
        n_tests++;
        if (end_idx != exp_end || cause != exp_cause || steps != exp_end) begin
            n_fail++;
            $display("FAIL %s_end: step %0d cause %0d count %0d, required step %0d cause %0d",
                     name, end_idx, cause, steps, exp_end, exp_cause);
        end
        n_tests++;
        if (epc != ep_model || bad != 0) begin
            n_fail++;
            $display("FAIL %s_seq: ep=%0d errs=%0d, required ep=%0d errs=0", name, epc, bad,
                     ep_model);
        end
        if (check_totals != 0) begin
            n_tests++;
            if (nr != exp_end || np != exp_end * P) begin
                n_fail++;
                $display("FAIL %s_totals: real=%0d plan=%0d, required %0d %0d", name, nr, np,
                         exp_end, exp_end * P);
            end
            @(negedge clk);
            n_tests++;
            if (episode_end !== 1'b0 || env_reset !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_pulse: end=%b env_reset=%b, required 0 1", name, episode_end,
                         env_reset);
            end
        end
    endtask

    task automatic test_step_limit();
        int rews[$];
        for (int i = 0; i < MAXS; i++) rews.push_back($urandom_range(0, GOAL - 1));
        check_episode("limit", rews, 3, 1);
    endtask

    task automatic test_simultaneous();
        int rews[$];
        for (int i = 0; i < MAXS - 1; i++) rews.push_back($urandom_range(0, GOAL - 1));
        rews.push_back(GOAL);
        check_episode("simul", rews, 1, 1);
    endtask

    task automatic test_random_episodes();
        for (int ep = 0; ep < 4; ep++) begin
            int rews[$];
            for (int i = 0; i < MAXS; i++)
                rews.push_back(($urandom_range(0, 11) == 0) ? GOAL : $urandom_range(0, GOAL - 1));
            check_episode("rand", rews, $urandom_range(0, 2), 0);
        end
    endtask

    task automatic test_abort_spurious();
        for (int c = 0; c < 64 && act_req !== 1'b1; c++) @(negedge clk);
        qupd_done = 1'b1;
        @(negedge clk);
        qupd_done = 1'b0;
        n_tests++;
        if (act_req !== 1'b1 || qupd_req !== 1'b0 || step_count !== 5'd0) begin
            n_fail++;
            $display("FAIL spurious_qupd: act_req=%b qupd_req=%b step=%0d, required 1 0 0",
                     act_req, qupd_req, step_count);
        end
        env_done = 1'b1; reward = 10'd0;
        @(negedge clk);
        reward = 10'(GOAL);
        @(negedge clk);
        env_done = 1'b0;
        n_tests++;
        if (qupd_req !== 1'b1 || qupd_plan !== 1'b0 || act_req !== 1'b0 || step_count !== 5'd0)
        begin
            n_fail++;
            $display("FAIL spurious_env: qupd_req=%b plan=%b act=%b step=%0d, required 1 0 0 0",
                     qupd_req, qupd_plan, act_req, step_count);
        end
        qupd_done = 1'b1;
        repeat (P + 1) @(negedge clk);
        qupd_done = 1'b0;
        n_tests++;
        if (episode_end !== 1'b0 || step_count !== 5'd1 || qupd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_reward: end=%b step=%0d qupd_req=%b, required 0 1 0",
                     episode_end, step_count, qupd_req);
        end
        @(negedge clk);
        env_done = 1'b1; reward = 10'd0;
        @(negedge clk);
        env_done = 1'b0; qupd_done = 1'b1;
        repeat (4) @(negedge clk);
        qupd_done = 1'b0;
        n_tests++;
        if (qupd_req !== 1'b1 || qupd_plan !== 1'b1 || step_count !== 5'd2) begin
            n_fail++;
            $display("FAIL abort_setup: qupd_req=%b plan=%b step=%0d, required 1 1 2", qupd_req,
                     qupd_plan, step_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (outs !== 8'h0 || step_count !== 5'd0 || episode_count !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_reset: outs=%b step=%0d ep=%0d, required all 0", outs,
                     step_count, episode_count);
        end
        rst = 1'b0;
        ep_model = 0;
        @(negedge clk);
    endtask

    task automatic test_done_restart();
        int plans = 0, resets = 0, ends = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 200 && done2 !== 1'b1; c++) begin
            if (qupd_req2 === 1'b1 && qupd_plan2 === 1'b1) plans++;
            if (env_reset2 === 1'b1) resets++;
            if (episode_end2 === 1'b1) ends++;
            @(negedge clk);
        end
        n_tests++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || episode_count2 !== 8'd2) begin
            n_fail++;
            $display("FAIL done_state: done=%b busy=%b ep=%0d, required 1 0 2", done2, busy2,
                     episode_count2);
        end
        n_tests++;
        if (plans != 0 || resets != 2 || ends != 2) begin
            n_fail++;
            $display("FAIL done_events: plans=%0d resets=%0d ends=%0d, required 0 2 2", plans,
                     resets, ends);
        end
        @(negedge clk);
        n_tests++;
        if (done2 !== 1'b1 || episode_count2 !== 8'd2 || act_req2 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: done=%b ep=%0d act=%b, required 1 2 0", done2,
                     episode_count2, act_req2);
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n_tests++;
        if (env_reset2 !== 1'b1 || episode_count2 !== 8'd0 || done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: env_reset=%b ep=%0d done=%b, required 1 0 0", env_reset2,
                     episode_count2, done2);
        end
        @(negedge clk);
        n_tests++;
        if (act_req2 !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_act: act_req=%b, required 1", act_req2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_goal_first();
        test_step_limit();
        test_simultaneous();
        test_random_episodes();
        test_abort_spurious();
        test_done_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
